// File: rtl/exp_bus_cap.sv
// exp_bus_cap: turns the raw asynchronous console expansion bus into clean,
// single-clock read/write events for the downstream device hub.
// Strobes and bus lines are synchronized through equal-depth pipelines.
// A filtered FSM then qualifies cycles, latches address/data and pulses cyc_rd/cyc_wr.
// A saturating counter records oe/we-both-active protocol violations.
module exp_bus_cap #(
    parameter int ADDR_W   = 21,
    parameter int SYNC_STG = 2,
    parameter int FILT     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [7:0]        bus_dat,
    input  logic              bus_ce_n,
    input  logic              bus_oe_n,
    input  logic              bus_we_n,
    output logic [ADDR_W-1:0] cyc_addr,
    output logic [7:0]        cyc_dat,
    output logic              cyc_rd,
    output logic              cyc_wr,
    output logic              cyc_act,
    output logic [7:0]        err_cnt
);

    localparam logic [3:0] FILT_W = 4'(FILT);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        ARM,
        RD,
        WR,
        REL
    } state_t;

    // Synchronizer pipelines; strobes idle high, bus lines idle low.
    logic [SYNC_STG-1:0] r_ceSync;
    logic [SYNC_STG-1:0] r_oeSync;
    logic [SYNC_STG-1:0] r_weSync;
    logic [SYNC_STG-1:0] r_fill;
    logic [ADDR_W-1:0]   r_addrSync [SYNC_STG];
    logic [7:0]          r_datSync  [SYNC_STG];

    state_t      r_state;
    state_t      w_nextState;
    logic [2:0]  r_cnt;
    logic [2:0]  w_nextCnt;

    logic [ADDR_W-1:0] r_cycAddr;
    logic [7:0]        r_cycDat;
    logic [7:0]        r_shadow;
    logic [7:0]        r_errCnt;
    logic              r_cycRd;
    logic              r_cycWr;
    logic              r_cycAct;

    logic              w_ceN;
    logic              w_oeN;
    logic              w_weN;
    logic              w_syncFull;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_dat;
    logic              w_idleAll;
    logic              w_start;
    logic              w_rdEnd;
    logic              w_wrEnd;
    logic              w_wrHold;
    logic              w_cntHit;
    logic              w_armHit;

    logic              w_qualify;
    logic              w_rdPulse;
    logic              w_wrDone;
    logic              w_cycEnd;
    logic              w_violation;
    logic              w_capture;

    // Shift every bus line through the same number of flops so address and
    // data stay aligned with the strobes; r_fill marks when the pipe holds
    // real samples rather than reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ceSync <= '1;
            r_oeSync <= '1;
            r_weSync <= '1;
            r_fill   <= '0;
            for (int i = 0; i < SYNC_STG; i++) begin
                r_addrSync[i] <= '0;
                r_datSync[i]  <= '0;
            end
        end else begin
            r_ceSync <= {r_ceSync[SYNC_STG-2:0], bus_ce_n};
            r_oeSync <= {r_oeSync[SYNC_STG-2:0], bus_oe_n};
            r_weSync <= {r_weSync[SYNC_STG-2:0], bus_we_n};
            r_fill   <= {r_fill[SYNC_STG-2:0], 1'b1};
            r_addrSync[0] <= bus_addr;
            r_datSync[0]  <= bus_dat;
            for (int i = 1; i < SYNC_STG; i++) begin
                r_addrSync[i] <= r_addrSync[i-1];
                r_datSync[i]  <= r_datSync[i-1];
            end
        end
    end

    assign w_ceN      = r_ceSync[SYNC_STG-1];
    assign w_oeN      = r_oeSync[SYNC_STG-1];
    assign w_weN      = r_weSync[SYNC_STG-1];
    assign w_syncFull = r_fill[SYNC_STG-1];
    assign w_addr     = r_addrSync[SYNC_STG-1];
    assign w_dat      = r_datSync[SYNC_STG-1];

    assign w_idleAll = w_ceN & w_oeN & w_weN & w_syncFull;
    assign w_start   = ~w_ceN & (~w_oeN | ~w_weN);
    assign w_rdEnd   = w_ceN | w_oeN;
    assign w_wrEnd   = w_ceN | w_weN;
    assign w_wrHold  = ~w_ceN & ~w_weN;

    // The sample that moved IDLE to ARM counts toward the filter, so ARM
    // needs one sample fewer than the other states.
    assign w_cntHit = ({1'b0, r_cnt} + 4'd1) >= FILT_W;
    assign w_armHit = ({1'b0, r_cnt} + 4'd2) >= FILT_W;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Next-state, filter counter and the one-cycle action strobes for the datapath.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_qualify   = 1'b0;
        w_rdPulse   = 1'b0;
        w_wrDone    = 1'b0;
        w_cycEnd    = 1'b0;
        w_violation = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            WAIT_IDLE: begin
                if (w_idleAll) begin
                    if (w_cntHit) begin
                        w_nextState = IDLE;
                        w_nextCnt   = '0;
                    end else begin
                        w_nextCnt = r_cnt + 3'd1;
                    end
                end else begin
                    w_nextCnt = '0;
                end
            end
            IDLE: begin
                w_nextCnt = '0;
                if (w_start) begin
                    w_nextState = ARM;
                end
            end
            ARM: begin
                if (!w_start) begin
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                end else if (w_armHit) begin
                    w_qualify = 1'b1;
                    w_nextCnt = '0;
                    if (!w_weN) begin
                        w_nextState = WR;
                        w_capture   = 1'b1;
                        w_violation = ~w_oeN;
                    end else begin
                        w_nextState = RD;
                        w_rdPulse   = 1'b1;
                    end
                end else begin
                    w_nextCnt = r_cnt + 3'd1;
                end
            end
            RD: begin
                if (w_rdEnd) begin
                    if (w_cntHit) begin
                        w_nextState = IDLE;
                        w_nextCnt   = '0;
                        w_cycEnd    = 1'b1;
                    end else begin
                        w_nextCnt = r_cnt + 3'd1;
                    end
                end else begin
                    w_nextCnt = '0;
                end
            end
            WR: begin
                w_capture = w_wrHold;
                if (w_wrEnd) begin
                    if (w_cntHit) begin
                        w_nextState = IDLE;
                        w_nextCnt   = '0;
                        w_wrDone    = 1'b1;
                        w_cycEnd    = 1'b1;
                    end else begin
                        w_nextCnt = r_cnt + 3'd1;
                    end
                end else begin
                    w_nextCnt = '0;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
            end
        endcase
    end

    // Output registers: address latch, write shadow, pulses, activity flag and violation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycAddr <= '0;
            r_cycDat  <= '0;
            r_shadow  <= '0;
            r_errCnt  <= '0;
            r_cycRd   <= 1'b0;
            r_cycWr   <= 1'b0;
            r_cycAct  <= 1'b0;
        end else begin
            r_cycRd <= w_rdPulse;
            r_cycWr <= w_wrDone;
            if (w_qualify) begin
                r_cycAddr <= w_addr;
                r_cycAct  <= 1'b1;
            end else if (w_cycEnd) begin
                r_cycAct <= 1'b0;
            end
            if (w_capture) begin
                r_shadow <= w_dat;
            end
            if (w_wrDone) begin
                r_cycDat <= r_shadow;
            end
            if (w_violation && (r_errCnt != 8'hFF)) begin
                r_errCnt <= r_errCnt + 8'd1;
            end
        end
    end

    assign cyc_addr = r_cycAddr;
    assign cyc_dat  = r_cycDat;
    assign cyc_rd   = r_cycRd;
    assign cyc_wr   = r_cycWr;
    assign cyc_act  = r_cycAct;
    assign err_cnt  = r_errCnt;

endmodule

// File: tb/tb_exp_bus_cap.sv
// tb_exp_bus_cap: drives transaction-level bus cycles into exp_bus_cap and
// checks the produced events against an expected-event queue.
`timescale 1ns/1ps
module tb_exp_bus_cap;

    localparam int ADDR_W   = 21;
    localparam int SYNC_STG = 2;
    localparam int FILT     = 2;
    localparam int LAT_MIN  = SYNC_STG + FILT - 1;
    localparam int LAT_MAX  = SYNC_STG + FILT + 1;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] busAddr;
    logic [7:0]        busDat;
    logic              ceN;
    logic              oeN;
    logic              weN;
    logic [ADDR_W-1:0] cyc_addr;
    logic [7:0]        cyc_dat;
    logic              cyc_rd;
    logic              cyc_wr;
    logic              cyc_act;
    logic [7:0]        err_cnt;

    typedef struct {
        bit                isWr;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        dat;
        logic [7:0]        err;
        int                start;
    } exp_t;

    exp_t expQ[$];

    int checks   = 0;
    int failures = 0;
    int cycCount = 0;

    logic [ADDR_W-1:0] modelAddr = '0;
    logic [7:0]        modelDat  = '0;
    logic [7:0]        modelErr  = '0;

    exp_bus_cap #(
        .ADDR_W  (ADDR_W),
        .SYNC_STG(SYNC_STG),
        .FILT    (FILT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus_addr(busAddr),
        .bus_dat (busDat),
        .bus_ce_n(ceN),
        .bus_oe_n(oeN),
        .bus_we_n(weN),
        .cyc_addr(cyc_addr),
        .cyc_dat (cyc_dat),
        .cyc_rd  (cyc_rd),
        .cyc_wr  (cyc_wr),
        .cyc_act (cyc_act),
        .err_cnt (err_cnt)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so event latencies can be measured in cycles.
    always @(posedge clk) cycCount <= cycCount + 1;

    // Hard stop if the run wanders off.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, actual, expected, cycCount);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Every cycle: pulses must match the next expected event in kind, address, data, error count and latency.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cyc_rd && cyc_wr) begin
                checkOutput("rd_wr_exclusive", 32'd1, 32'd0);
            end else if (cyc_rd || cyc_wr) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pulse", {30'd0, cyc_rd, cyc_wr}, 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("pulse_kind_wr", 32'(cyc_wr), 32'(e.isWr));
                    checkOutput("pulse_addr", 32'(cyc_addr), 32'(e.addr));
                    checkOutput("pulse_dat", 32'(cyc_dat), 32'(e.dat));
                    checkOutput("pulse_err", 32'(err_cnt), 32'(e.err));
                    checkRange(e.isWr ? "wr_latency" : "rd_latency", cycCount - e.start, LAT_MIN, LAT_MAX);
                end
            end
        end
    end

    task automatic idleBus(input int n);
        ceN = 1'b1;
        oeN = 1'b1;
        weN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic applyRead(input logic [ADDR_W-1:0] a, input int hold);
        exp_t e;
        busAddr = a;
        busDat  = 8'($urandom);
        ceN = 1'b0;
        oeN = 1'b0;
        weN = 1'b1;
        e.isWr = 1'b0; e.addr = a; e.dat = modelDat; e.err = modelErr; e.start = cycCount;
        expQ.push_back(e);
        modelAddr = a;
        repeat (hold) @(negedge clk);
        checkOutput("rd_act_held", 32'(cyc_act), 32'd1);
        ceN = 1'b1;
        oeN = 1'b1;
        busAddr = ~a;
    endtask

    task automatic applyWrite(input logic [ADDR_W-1:0] a, input logic [7:0] d, input int hold, input bit both);
        exp_t e;
        busAddr = a;
        busDat  = d;
        ceN = 1'b0;
        weN = 1'b0;
        oeN = both ? 1'b0 : 1'b1;
        if (both && modelErr != 8'hFF) modelErr = modelErr + 8'd1;
        repeat (hold) @(negedge clk);
        checkOutput("wr_act_held", 32'(cyc_act), 32'd1);
        ceN = 1'b1;
        weN = 1'b1;
        oeN = 1'b1;
        busDat  = ~d;
        busAddr = ~a;
        modelAddr = a;
        modelDat  = d;
        e.isWr = 1'b1; e.addr = a; e.dat = d; e.err = modelErr; e.start = cycCount;
        expQ.push_back(e);
    endtask

    // One-clock oe glitch inside a ce window: nothing may qualify.
    task automatic applyGlitch();
        busAddr = 21'($urandom);
        ceN = 1'b0;
        oeN = 1'b0;
        @(negedge clk);
        oeN = 1'b1;
        @(negedge clk);
        ceN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("glitch_act_low", 32'(cyc_act), 32'd0);
        end
    endtask

    // Wait (bounded) for all expected events, then compare settled outputs with the model.
    task automatic drainCheck(input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < 16) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_drained"}, 32'(expQ.size()), 32'd0);
        expQ.delete();
        checkOutput({tag, "_act_idle"}, 32'(cyc_act), 32'd0);
        checkOutput({tag, "_addr_hold"}, 32'(cyc_addr), 32'(modelAddr));
        checkOutput({tag, "_dat_hold"}, 32'(cyc_dat), 32'(modelDat));
        checkOutput({tag, "_err"}, 32'(err_cnt), 32'(modelErr));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd"}, 32'(cyc_rd), 32'd0);
        checkOutput({tag, "_wr"}, 32'(cyc_wr), 32'd0);
        checkOutput({tag, "_act"}, 32'(cyc_act), 32'd0);
        checkOutput({tag, "_addr"}, 32'(cyc_addr), 32'd0);
        checkOutput({tag, "_dat"}, 32'(cyc_dat), 32'd0);
        checkOutput({tag, "_err"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        int kind;
        int gap;
        rst_n   = 1'b0;
        busAddr = '0;
        busDat  = '0;
        ceN = 1'b1;
        oeN = 1'b1;
        weN = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        idleBus(8);

        // Directed read.
        applyRead(21'h1FF800, 10);
        idleBus(8);
        drainCheck("read");
        checkOutput("read_addr_literal", 32'(cyc_addr), 32'h1FF800);

        // Directed write.
        applyWrite(21'h0C0123, 8'hA5, 8, 1'b0);
        idleBus(8);
        drainCheck("write");
        checkOutput("write_dat_literal", 32'(cyc_dat), 32'hA5);
        checkOutput("write_addr_literal", 32'(cyc_addr), 32'h0C0123);

        // Glitch.
        applyGlitch();
        drainCheck("glitch");

        // Single violation.
        applyWrite(21'h012345, 8'h3C, 8, 1'b1);
        idleBus(8);
        drainCheck("viol");
        checkOutput("viol_err_literal", 32'(err_cnt), 32'd1);
        checkOutput("viol_dat_literal", 32'(cyc_dat), 32'h3C);

        // Back-to-back read then write with a 3-clock gap.
        applyRead(21'h155555, 8);
        idleBus(3);
        applyWrite(21'h0AAAAA, 8'h5A, 8, 1'b0);
        idleBus(8);
        drainCheck("b2b");

        // Drive the violation counter into saturation.
        for (int i = 0; i < 300; i++) begin
            applyWrite(21'($urandom), 8'($urandom), 8, 1'b1);
            idleBus(6);
            drainCheck("sat");
        end
        checkOutput("sat_err_literal", 32'(err_cnt), 32'd255);

        // Reset in the middle of a write, released with the strobes still low.
        busAddr = 21'h033333;
        busDat  = 8'h77;
        ceN = 1'b0;
        weN = 1'b0;
        oeN = 1'b1;
        repeat (7) @(negedge clk);
        checkOutput("pre_reset_act", 32'(cyc_act), 32'd1);
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        modelAddr = '0;
        modelDat  = '0;
        modelErr  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("post_reset_act", 32'(cyc_act), 32'd0);
        end
        idleBus(8);
        drainCheck("post_reset");
        applyRead(21'h100001, 8);
        idleBus(8);
        drainCheck("post_reset_read");

        // Randomized mix of reads, writes, violations and glitches.
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 3));
            gap  = ($urandom_range(0, 3) == 0) ? 3 : int'($urandom_range(6, 8));
            case (kind)
                0: applyRead(21'($urandom), int'($urandom_range(6, 12)));
                1: applyWrite(21'($urandom), 8'($urandom), int'($urandom_range(6, 12)), 1'b0);
                2: applyWrite(21'($urandom), 8'($urandom), int'($urandom_range(6, 12)), 1'b1);
                default: applyGlitch();
            endcase
            idleBus(gap);
            if (gap >= 6) drainCheck("rand");
        end
        idleBus(8);
        drainCheck("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exp_bus_cap.md
Name: exp_bus_cap

Overview:
- Front stage of the expansion-port path; sits directly upstream of the expansion device hub and its devices (CD-ROM, backup RAM).
- Takes the raw, asynchronous console bus (address, data, CE/OE/WE strobes) and produces clean, single-clock bus-cycle events for the devices.
- Each event carries the latched address, the write data where applicable, and a one-cycle read or write pulse.
- Rejects strobe glitches and counts protocol violations.

Parameters:
- ADDR_W, 21, console bus address width.
- SYNC_STG, 2, synchronizer flops per strobe, legal 2..3.
- FILT, 2, consecutive cycles a strobe level must hold before it is accepted, legal 1..7.

Ports:
- clk  in  1  system clock, sole clock domain.
- rst_n  in  1  asynchronous active-low reset.
- bus_addr  in  ADDR_W  console address, asynchronous.
- bus_dat  in  8  console data toward cartridge, asynchronous.
- bus_ce_n  in  1  expansion chip enable, active low, asynchronous.
- bus_oe_n  in  1  read strobe, active low, asynchronous.
- bus_we_n  in  1  write strobe, active low, asynchronous.
- cyc_addr  out  ADDR_W  address of current/last cycle.
- cyc_dat  out  8  write data of last write cycle.
- cyc_rd  out  1  one-cycle pulse, read cycle qualified.
- cyc_wr  out  1  one-cycle pulse, write cycle complete, cyc_dat valid.
- cyc_act  out  1  high while a qualified cycle is in progress.
- err_cnt  out  8  saturating protocol-violation counter.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values:
  - All outputs 0.
  - FSM in WAIT_IDLE.
  - Synchronizer and delay flops 0; strobe synchronizer flops reset to 1 (inactive).
- Synchronization:
  - ce_n, oe_n and we_n each pass through SYNC_STG flops.
  - bus_addr and bus_dat pass through the same number of flops, so they stay aligned with the strobes. No multi-bit synchronizer; the bus is stable while its strobes are asserted.
- Filtering:
  - A 3-bit counter per filtered condition.
  - A level is accepted only after FILT consecutive identical synchronized samples.
- FSM states: WAIT_IDLE, IDLE, ARM, RD, WR, REL.
  - WAIT_IDLE: stays until ce, oe and we have all been synchronized-inactive for FILT cycles, then goes to IDLE. A cycle already in progress when reset is released is ignored.
  - IDLE: when ce is low and (oe or we) is low, goes to ARM and clears the filter counter.
  - ARM:
    - If the condition drops before FILT cycles, return to IDLE. No pulse, no error.
    - On reaching FILT cycles: latch cyc_addr from the delayed address and set cyc_act=1.
    - If oe is active and we is not: go to RD and pulse cyc_rd for exactly one cycle.
    - If we is active (with or without oe): go to WR.
    - If oe and we are both active: increment err_cnt (saturate at 255) and treat the cycle as a write.
  - RD: wait until oe or ce has been inactive for FILT cycles, then go to IDLE with cyc_act=0.
  - WR:
    - Every cycle that we and ce are both low, capture the delayed data into a shadow register.
    - When we or ce has been inactive for FILT cycles: copy the shadow register to cyc_dat, pulse cyc_wr for one cycle, set cyc_act=0, go to IDLE.
    - The captured data is the last sample taken while the strobe was still low.
- Latency:
  - Read: bus_oe_n/ce_n falling edge to cyc_rd is SYNC_STG+FILT cycles, ±1 cycle of sampling uncertainty.
  - Write: bus_we_n rising edge to cyc_wr is SYNC_STG+FILT cycles, ±1.
- Pulse and hold rules:
  - cyc_rd and cyc_wr are never high together.
  - At most one pulse per bus cycle.
  - cyc_addr holds its value between cycles.
- Boundary conditions:
  - ce releasing before we: treated as write completion.
  - ce dropping while in RD: cycle ends, no second pulse.
  - rst_n asserted mid-cycle: outputs clear immediately (async); after release, the FSM returns to WAIT_IDLE.

Test Plan:
- Read: ce_n=0, oe_n=0 held 10 clk, addr=0x1FF800 -> one cyc_rd pulse 4±1 clk after the fall (defaults); cyc_addr=0x1FF800; cyc_act high until ~4 clk after oe_n rises.
- Write: ce_n=0, we_n=0 for 8 clk, bus_dat=0xA5, addr=0x0C0123 -> cyc_wr single pulse 4±1 clk after we_n rises; cyc_dat=0xA5; cyc_addr=0x0C0123.
- Glitch: oe_n low for 1 clk with ce_n=0 -> no pulse, cyc_act stays 0, err_cnt unchanged.
- Violation: oe_n and we_n both low 8 clk, data=0x3C -> cyc_wr pulse with cyc_dat=0x3C, no cyc_rd, err_cnt 0→1; repeat 300 times -> err_cnt=255.
- Reset mid-cycle: assert rst_n=0 during WR -> all outputs 0 at once; release with we_n still low -> no pulse until strobes go idle, then the next clean read qualifies normally.
- Back-to-back: read, then write with 3-clk idle gap -> exactly one cyc_rd, then one cyc_wr, with correct respective addresses.
